// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the shift-register serial link:
// far-end select codes, transmitter state encoding and default word width.
package serial_link_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   localparam logic [1:0] SEL_CLEAR   = 2'b00;
   localparam logic [1:0] SEL_HOLD    = 2'b01;
   localparam logic [1:0] SEL_SHIFT   = 2'b10;
   // Reserved for a left-shifting receiver; never driven by the transmitter.
   localparam logic [1:0] SEL_SHIFT_L = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      SHIFT  = 2'd2,
      PARITY = 2'd3
   } tx_state_t;

endpackage

// File: rtl/serial_transmitter_if.sv
// Bundle between the word source (master) and the serial transmitter (slave).
// Handshake: a word transfers on a rising edge where load_valid && load_ready; load_ready is only high in IDLE.
interface serial_transmitter_if #(
   parameter int DATA_WIDTH = serial_link_pkg::DATA_WIDTH_DEF
);

   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_valid;
   logic                  load_ready;
   logic                  serial_output;
   logic [1:0]            rx_select;
   logic                  parity_out;
   logic                  busy;
   logic                  done;

   modport master (
      output load_data, load_valid,
      input  load_ready, serial_output, rx_select, parity_out, busy, done
   );

   modport slave (
      input  load_data, load_valid,
      output load_ready, serial_output, rx_select, parity_out, busy, done
   );

endinterface

// File: rtl/serial_transmitter_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the last cycle of each period.
// Holding i_restart keeps the count at 0 so a new period begins when it is released.
module bit_timer #(
   parameter int BIT_CYCLES = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam int            PW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [PW-1:0] LAST = PW'(BIT_CYCLES - 1);

   logic [PW-1:0] r_cnt;

   assign o_tick = (r_cnt == LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_restart || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmitter: CLEAR, DATA_WIDTH data bits LSB first, then an even-parity bit,
// driving the far-end shift register's select code alongside the serial line.
module serial_transmitter
   import serial_link_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BIT_CYCLES = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   serial_transmitter_if.slave  bus,
   output tx_state_t            o_state
);

   localparam int            BW       = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   tx_state_t             r_state;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic [BW-1:0]         r_bit_cnt;
   logic                  r_serial;
   logic [1:0]            r_sel;
   logic                  r_parity;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_ready;

   logic                  w_tick;
   logic                  w_restart;
   logic [DATA_WIDTH-1:0] w_shreg_next;

   // State changes only happen on a tick, so the timer only needs pinning while idle.
   assign w_restart    = (r_state == IDLE);
   assign w_shreg_next = r_shreg >> 1;

   bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_serial  <= 1'b1;
         r_sel     <= SEL_HOLD;
         r_parity  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ready   <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.load_valid && r_ready) begin
                  r_state   <= CLEAR;
                  r_shreg   <= bus.load_data;
                  r_parity  <= ^bus.load_data;
                  r_bit_cnt <= '0;
                  r_sel     <= SEL_CLEAR;
                  r_serial  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_ready   <= 1'b0;
               end
            end
            CLEAR: begin
               if (w_tick) begin
                  r_state  <= SHIFT;
                  r_sel    <= SEL_SHIFT;
                  r_serial <= r_shreg[0];
               end
            end
            SHIFT: begin
               if (w_tick) begin
                  r_shreg   <= w_shreg_next;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state  <= PARITY;
                     r_sel    <= SEL_HOLD;
                     r_serial <= r_parity;
                  end else begin
                     r_serial <= w_shreg_next[0];
                  end
               end
            end
            PARITY: begin
               if (w_tick) begin
                  r_state   <= IDLE;
                  r_bit_cnt <= '0;
                  r_sel     <= SEL_HOLD;
                  r_serial  <= 1'b1;
                  r_parity  <= 1'b0;
                  r_busy    <= 1'b0;
                  r_ready   <= 1'b1;
                  r_done    <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_shreg   <= '0;
               r_bit_cnt <= '0;
               r_sel     <= SEL_HOLD;
               r_serial  <= 1'b1;
               r_parity  <= 1'b0;
               r_busy    <= 1'b0;
               r_ready   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.serial_output = r_serial;
   assign bus.rx_select     = r_sel;
   assign bus.parity_out    = r_parity;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.load_ready    = r_ready;
   assign o_state           = r_state;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: BIT_CYCLES=1 and BIT_CYCLES=3 instances,
// a behavioural far-end receiver and an expected-word queue.
module tb_serial_transmitter;
  import serial_link_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  serial_transmitter_if #(.DATA_WIDTH(8)) bus1 ();
  serial_transmitter_if #(.DATA_WIDTH(8)) bus3 ();
  tx_state_t st1, st3;

  serial_transmitter #(.DATA_WIDTH(8), .BIT_CYCLES(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1), .o_state(st1)
  );
  serial_transmitter #(.DATA_WIDTH(8), .BIT_CYCLES(3)) dut3 (
    .CLK(CLK), .RST(RST), .bus(bus3), .o_state(st3)
  );

  // observation vector: {rx_select, serial_output, busy, done, load_ready, parity_out}
  localparam logic [6:0] IDLE_OBS = 7'b01_1_0_0_1_0;
  logic [6:0] obs1, obs3;
  always_comb obs1 = {bus1.rx_select, bus1.serial_output, bus1.busy, bus1.done, bus1.load_ready, bus1.parity_out};
  always_comb obs3 = {bus3.rx_select, bus3.serial_output, bus3.busy, bus3.done, bus3.load_ready, bus3.parity_out};

  // far-end receiver: shifts into MSB whenever select is SHIFT
  logic [7:0] rx_word = 8'h00;
  always @(posedge CLK) begin
    if (bus1.rx_select == SEL_SHIFT) rx_word <= {bus1.serial_output, rx_word[7:1]};
  end

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         hold;
    int         inj;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit use3, input logic [7:0] d, input logic v);
    if (use3) begin
      bus3.load_data = d; bus3.load_valid = v;
    end else begin
      bus1.load_data = d; bus1.load_valid = v;
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge of the done cycle.
  task automatic run_frame(input bit use3, input logic [7:0] d, input logic par,
                           input bit hold, input int inj);
    int bc;
    int nc;
    logic [6:0] cur;
    logic [6:0] exp;
    logic       bitv;
    bc = use3 ? 3 : 1;
    nc = 10 * bc;
    cur = use3 ? obs3 : obs1;
    check("ready_before_load", {7'd0, cur[1]}, 8'd1);
    drive(use3, d, 1'b1);
    @(posedge CLK);
    if (!use3) exp_q.push_back(d);
    @(negedge CLK);
    for (int i = 0; i < nc; i++) begin
      cur = use3 ? obs3 : obs1;
      if (i < bc) begin
        exp = {SEL_CLEAR, 1'b1, 1'b1, 1'b0, 1'b0, par};
      end else if (i < 9 * bc) begin
        bitv = d[(i - bc) / bc];
        exp = {SEL_SHIFT, bitv, 1'b1, 1'b0, 1'b0, par};
      end else begin
        exp = {SEL_HOLD, par, 1'b1, 1'b0, 1'b0, par};
      end
      check(use3 ? "frame_cycle_bc3" : "frame_cycle_bc1", {1'b0, cur}, {1'b0, exp});
      if (i == inj) drive(use3, 8'h55, 1'b1);
      else if (i == inj + 1) drive(use3, d, 1'b0);
      else if (i == 0 && !hold) drive(use3, d, 1'b0);
      @(negedge CLK);
    end
    cur = use3 ? obs3 : obs1;
    check("done_cycle", {1'b0, cur}, {1'b0, 7'b01_1_0_1_1_0});
    check("done_state_idle", {6'd0, use3 ? st3 : st1}, {6'd0, IDLE});
    if (!use3) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 8'd0, 8'd1);
      end else begin
        check("rx_word", rx_word, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, -1};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, -1};
    vecs[2] = '{8'hC1, 1'b1, 1'b0, -1};
    vecs[3] = '{8'h96, 1'b0, 1'b0, 4};
    vecs[4] = '{8'h00, 1'b0, 1'b0, -1};
    vecs[5] = '{8'h80, 1'b1, 1'b0, -1};

    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    @(negedge CLK);
    check("reset_obs_bc1", {1'b0, obs1}, {1'b0, IDLE_OBS});
    check("reset_state_bc1", {6'd0, st1}, {6'd0, IDLE});
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("idle_hold_bc1", {1'b0, obs1}, {1'b0, IDLE_OBS});
    end
    check("idle_hold_bc3", {1'b0, obs3}, {1'b0, IDLE_OBS});

    // Table: vec 1 holds valid into vec 2 for back-to-back; vec 3 pulses 8'h55 mid-shift.
    for (int v = 0; v < 6; v++) begin
      run_frame(1'b0, vecs[v].data, vecs[v].par, vecs[v].hold, vecs[v].inj);
    end
    @(negedge CLK);

    // Reset during the 4th data bit.
    drive(1'b0, 8'hE7, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 8'hE7, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge CLK);
    check("fourth_bit_shift", {6'd0, obs1[6:5]}, {6'd0, SEL_SHIFT});
    #1 RST = 1'b1;
    #1;
    check("mid_reset_obs", {1'b0, obs1}, {1'b0, IDLE_OBS});
    check("mid_reset_state", {6'd0, st1}, {6'd0, IDLE});
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("no_done_after_reset", {1'b0, obs1}, {1'b0, IDLE_OBS});
    end
    run_frame(1'b0, 8'hFF, 1'b0, 1'b0, -1);
    @(negedge CLK);

    // BIT_CYCLES=3 instance: 30-cycle frame, odd parity word.
    run_frame(1'b1, 8'h07, 1'b1, 1'b0, -1);
    @(negedge CLK);
    check("idle_after_bc3", {1'b0, obs3}, {1'b0, IDLE_OBS});

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Parallel-to-serial transmitter for the shift-register serial link. It accepts an 8-bit word over a valid/ready handshake and shifts it out LSB first, one bit per bit period. Alongside the data it drives the far-end shift register's 2-bit select code (clear, shift, hold) and then sends one even-parity bit. It sits on the transmit side of the link, opposite the shift-register receiver, and drives that receiver's `select` and `serial_input` directly.

## Interface
- `DATA_WIDTH`, 8: word width; the bench covers only 8.
- `BIT_CYCLES`, 1: clock cycles per bit period; must be ≥1.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `load_data`  in  DATA_WIDTH  word to transmit.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  transmitter can accept a word (IDLE only).
- `serial_output`  out  1  serial line, LSB first; idles high.
- `rx_select`  out  2  far-end shift-register command: 00 clear, 01 hold, 10 shift.
- `parity_out`  out  1  even parity (XOR) of the word in flight.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values:
  - `serial_output`=1, `rx_select`=01, `parity_out`=0.
  - `busy`=0, `done`=0, `load_ready`=1.
  - State IDLE; the shift register and counters are cleared.
- IDLE:
  - Outputs hold their reset values.
  - On `load_valid && load_ready`: capture `load_data` into the shift register, latch `parity_out` = ^`load_data`, go to CLEAR.
- CLEAR: one bit period.
  - `rx_select`=00, `serial_output`=1, `busy`=1.
- SHIFT: DATA_WIDTH bit periods.
  - `rx_select`=10, `serial_output`=shreg[0].
  - At the end of each bit period, shreg shifts right with 0 fill and the bit counter increments.
  - After the last bit, go to PARITY.
- PARITY: one bit period.
  - `rx_select`=01, `serial_output`=`parity_out`.
  - At the end, go to IDLE and assert `done` for the first IDLE cycle.
- `load_data` and `load_valid` are ignored outside IDLE. No queueing.
- The bit-period counter counts 0..BIT_CYCLES-1. It reloads to 0 on every state change.
- Bit counter width is $clog2(DATA_WIDTH+1). Period counter width is max(1,$clog2(BIT_CYCLES)).
- Illegal state encodings return to IDLE.

## Timing
- All outputs are registered.
- A handshake on edge k puts CLEAR on the outputs from cycle k+1.
- The frame occupies (DATA_WIDTH+2)×BIT_CYCLES cycles. For 8 bits and BIT_CYCLES=1, that is 10 cycles.
- `done` is high in cycle k+1+(DATA_WIDTH+2)×BIT_CYCLES, together with `load_ready`=1.
- Back-to-back frames: a load accepted in the `done` cycle starts CLEAR on the next cycle, so there is exactly one IDLE cycle between frames.
- `rx_select` and `serial_output` change on the same edge, so the receiver samples each data bit during the cycles where `rx_select`=10.
- `RST` asserted mid-frame forces all reset values immediately. No `done` is produced and the partial frame is discarded.
- `load_valid` held high during a frame is not accepted until IDLE.

## Structure
- Shared package `serial_link_pkg`, used by both ends of the link, holds:
  - select constants SEL_CLEAR=2'b00, SEL_HOLD=2'b01, SEL_SHIFT=2'b10, SEL_SHIFT_L=2'b11 (SEL_SHIFT_L is reserved and never driven here);
  - the tx state enum {IDLE, CLEAR, SHIFT, PARITY};
  - the default DATA_WIDTH.
- One sub-module, `bit_timer`: the BIT_CYCLES period counter with a `restart` input and a `tick` output that pulses on the last cycle of each period.
- The FSM, shift register and parity latch live in `serial_transmitter`.

## Test plan
- Reset then idle, BIT_CYCLES=1: `serial_output`=1, `rx_select`=01, `load_ready`=1, `busy`=0; no change over 20 cycles with `load_valid`=0.
- Load 8'hA5, BIT_CYCLES=1:
  - `rx_select` sequence is 00, then 10×8, then 01.
  - Serial bits during shift are 1,0,1,0,0,1,0,1; parity bit is 0.
  - `done` arrives 10 cycles after the cycle following the accept edge.
- Load 8'h07, BIT_CYCLES=3: each bit is held 3 cycles; parity bit is 1; frame is 30 cycles.
- Loopback with 8'h3C then 8'hC1, `load_valid` held high:
  - A behavioural receiver shifts the serial bit into its MSB whenever `rx_select`=10.
  - It captures 8'h3C, then 8'hC1.
  - Exactly one IDLE cycle separates the frames.
- Assert `RST` during the 4th SHIFT bit: outputs return to reset values in the same cycle; no `done` pulse; the next load 8'hFF transmits cleanly with parity 0.
- Pulse `load_valid` with 8'h55 during SHIFT: ignored; the frame in flight is unchanged; `load_ready` stays 0 until IDLE.
